// File: rtl/cnet_reg_target.sv
// cnet_reg_target: CPCI register target with posted-write FIFO and ordered reads
//
// Bridges the CPCI register bus onto a single-outstanding internal register bus.
// Writes are posted into a FIFO and drained in order. A read waits until every
// earlier write has completed, then issues one internal read and returns its data.
//
// Ports
//   nclk            in   core clock, rising edge
//   reset_L         in   synchronous active-low reset
//   cpci_req        in   CPCI request, level, held until done
//   cpci_rd_wr_L    in   1 = read, 0 = write
//   cpci_addr       in   CPCI register address
//   cpci_data_wr    in   CPCI write data
//   cpci_wr_rdy     out  level, enough FIFO room to accept writes
//   cpci_rd_rdy     out  one-cycle pulse, cpci_data_rd valid
//   cpci_data_rd    out  read data, held until the next read completes
//   cpci_data_rd_en out  drive enable for cpci_data_rd
//   reg_req         out  internal request, held until reg_ack
//   reg_rd_wr_L     out  internal read/write select
//   reg_addr        out  internal address
//   reg_wr_data     out  internal write data
//   reg_ack         in   one-cycle internal completion
//   reg_rd_data     in   internal read data, valid with reg_ack
//   wr_overflow     out  one-cycle pulse, write dropped on a full FIFO
//   rd_abort        out  one-cycle pulse, read abandoned by CPCI
module cnet_reg_target #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 27,
   parameter int WR_FIFO_DEPTH = 8,
   parameter int WR_RDY_MARGIN = 5
) (
   input  logic                  nclk,
   input  logic                  reset_L,
   input  logic                  cpci_req,
   input  logic                  cpci_rd_wr_L,
   input  logic [ADDR_WIDTH-1:0] cpci_addr,
   input  logic [DATA_WIDTH-1:0] cpci_data_wr,
   output logic                  cpci_wr_rdy,
   output logic                  cpci_rd_rdy,
   output logic [DATA_WIDTH-1:0] cpci_data_rd,
   output logic                  cpci_data_rd_en,
   output logic                  reg_req,
   output logic                  reg_rd_wr_L,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [DATA_WIDTH-1:0] reg_wr_data,
   input  logic                  reg_ack,
   input  logic [DATA_WIDTH-1:0] reg_rd_data,
   output logic                  wr_overflow,
   output logic                  rd_abort
);
   localparam int PW = $clog2(WR_FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;

   typedef enum logic [2:0] {IDLE, RD_DRAIN, RD_WAIT, RD_RESP, RD_HOLD} state_t;

   logic                  req_d1_q, rd_wr_L_d1_q;
   logic [ADDR_WIDTH-1:0] addr_d1_q;
   logic [DATA_WIDTH-1:0] data_d1_q;

   logic [EW-1:0]         mem_q [WR_FIFO_DEPTH];
   logic [PW-1:0]         wptr_q, rptr_q;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [EW-1:0]         head;
   logic                  push, pop, full, empty, push_ok;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  abandon, rd_done, rd_issue, wr_issue;

   logic                  wr_rdy_q, wr_rdy_d;
   logic                  rd_rdy_q, data_rd_en_q;
   logic [DATA_WIDTH-1:0] data_rd_q, data_rd_d;
   logic                  reg_req_q, reg_req_d;
   logic                  reg_rd_wr_L_q, reg_rd_wr_L_d;
   logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
   logic [DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
   logic                  ovf_q, ovf_d;
   logic                  abort_q;

   always_comb begin
      head     = mem_q[rptr_q];
      push     = req_d1_q & ~rd_wr_L_d1_q;
      // Only an acknowledged internal write retires a FIFO entry.
      pop      = reg_ack & reg_req_q & ~reg_rd_wr_L_q;
      full     = cnt_q == CW'(WR_FIFO_DEPTH);
      empty    = cnt_q == '0;
      // A pop in the same cycle frees the slot the push needs.
      push_ok  = push & (~full | pop);
      ovf_d    = push & ~push_ok;
      cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
      wr_rdy_d = (CW'(WR_FIFO_DEPTH) - cnt_d) >= CW'(WR_RDY_MARGIN);
      abandon  = (state_q == RD_DRAIN || state_q == RD_WAIT) & ~req_d1_q;
      rd_done  = (state_q == RD_WAIT) & req_d1_q & reg_ack;
      // Read goes out only once every earlier write has completed internally.
      rd_issue = (state_q == RD_DRAIN) & req_d1_q & empty & ~reg_req_q;
      wr_issue = ~reg_req_q & ~empty;
      rd_addr_d = (state_q == IDLE & req_d1_q & rd_wr_L_d1_q) ? addr_d1_q : rd_addr_q;
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = (req_d1_q & rd_wr_L_d1_q) ? RD_DRAIN : IDLE;
         RD_DRAIN: state_d = abandon ? IDLE : rd_issue ? RD_WAIT : RD_DRAIN;
         RD_WAIT:  state_d = abandon ? IDLE : rd_done ? RD_RESP : RD_WAIT;
         RD_RESP:  state_d = RD_HOLD;
         RD_HOLD:  state_d = req_d1_q ? RD_HOLD : IDLE;
         default:  state_d = IDLE;
      endcase
      // An abandoned read drops its request; a write in flight during drain is kept.
      reg_req_d     = wr_issue | rd_issue |
                      (reg_req_q & ~reg_ack & ~(abandon & state_q == RD_WAIT));
      reg_rd_wr_L_d = rd_issue ? 1'b1 : wr_issue ? 1'b0 : reg_rd_wr_L_q;
      reg_addr_d    = rd_issue ? rd_addr_q : wr_issue ? head[EW-1:DATA_WIDTH] : reg_addr_q;
      reg_wr_data_d = wr_issue ? head[DATA_WIDTH-1:0] : reg_wr_data_q;
      data_rd_d     = rd_done ? reg_rd_data : data_rd_q;
   end

   always_ff @(posedge nclk) begin
      if (reset_L && push_ok) mem_q[wptr_q] <= {addr_d1_q, data_d1_q};
   end

   always_ff @(posedge nclk) begin
      if (!reset_L) begin
         req_d1_q      <= 1'b0;
         rd_wr_L_d1_q  <= 1'b0;
         addr_d1_q     <= '0;
         data_d1_q     <= '0;
         wptr_q        <= '0;
         rptr_q        <= '0;
         cnt_q         <= '0;
         state_q       <= IDLE;
         rd_addr_q     <= '0;
         wr_rdy_q      <= 1'b0;
         rd_rdy_q      <= 1'b0;
         data_rd_en_q  <= 1'b0;
         data_rd_q     <= '0;
         reg_req_q     <= 1'b0;
         reg_rd_wr_L_q <= 1'b0;
         reg_addr_q    <= '0;
         reg_wr_data_q <= '0;
         ovf_q         <= 1'b0;
         abort_q       <= 1'b0;
      end else begin
         req_d1_q      <= cpci_req;
         rd_wr_L_d1_q  <= cpci_rd_wr_L;
         addr_d1_q     <= cpci_addr;
         data_d1_q     <= cpci_data_wr;
         wptr_q        <= wptr_q + PW'(push_ok);
         rptr_q        <= rptr_q + PW'(pop);
         cnt_q         <= cnt_d;
         state_q       <= state_d;
         rd_addr_q     <= rd_addr_d;
         wr_rdy_q      <= wr_rdy_d;
         rd_rdy_q      <= rd_done;
         data_rd_en_q  <= rd_done;
         data_rd_q     <= data_rd_d;
         reg_req_q     <= reg_req_d;
         reg_rd_wr_L_q <= reg_rd_wr_L_d;
         reg_addr_q    <= reg_addr_d;
         reg_wr_data_q <= reg_wr_data_d;
         ovf_q         <= ovf_d;
         abort_q       <= abandon;
      end
   end

   assign cpci_wr_rdy     = wr_rdy_q;
   assign cpci_rd_rdy     = rd_rdy_q;
   assign cpci_data_rd    = data_rd_q;
   assign cpci_data_rd_en = data_rd_en_q;
   assign reg_req         = reg_req_q;
   assign reg_rd_wr_L     = reg_rd_wr_L_q;
   assign reg_addr        = reg_addr_q;
   assign reg_wr_data     = reg_wr_data_q;
   assign wr_overflow     = ovf_q;
   assign rd_abort        = abort_q;
endmodule
